// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-set controller.
package watch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned LIMIT_W = 7;
  localparam int unsigned FSEL_W  = 2;

  localparam logic [LIMIT_W-1:0] HR_MAX = LIMIT_W'(23);
  localparam logic [LIMIT_W-1:0] MS_MAX = LIMIT_W'(59);

  localparam logic [FSEL_W-1:0] FS_NONE = 2'd0;
  localparam logic [FSEL_W-1:0] FS_HR   = 2'd1;
  localparam logic [FSEL_W-1:0] FS_MIN  = 2'd2;
  localparam logic [FSEL_W-1:0] FS_SEC  = 2'd3;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_COMMIT  = 3'd4
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] msb;
    logic [DIGIT_W-1:0] lsb;
  } bcd2_t;

  typedef struct packed {
    bcd2_t hr;
    bcd2_t min;
    bcd2_t sec;
  } hms_t;

  // Field selection code presented while a state is active.
  function automatic logic [FSEL_W-1:0] field_of(state_e s);
    logic [FSEL_W-1:0] fs;
    fs = FS_NONE;
    unique case (s)
      ST_SET_HR:  fs = FS_HR;
      ST_SET_MIN: fs = FS_MIN;
      ST_SET_SEC: fs = FS_SEC;
      default:    fs = FS_NONE;
    endcase
    return fs;
  endfunction

endpackage

// File: rtl/watch_set_ctrl_if.sv
// Button, live-time and set-time signal bundle of the watch time-set controller.
interface watch_set_ctrl_if;

  logic              mode_btn;
  logic              inc_btn;
  watch_pkg::hms_t   cur;
  logic [3:0]        set_hr_msb;
  logic [3:0]        set_hr_lsb;
  logic [3:0]        set_min_msb;
  logic [3:0]        set_min_lsb;
  logic [3:0]        set_sec_msb;
  logic [3:0]        set_sec_lsb;
  logic              set_en;
  logic [1:0]        field_sel;

  modport master (
    output mode_btn, inc_btn, cur,
    input  set_hr_msb, set_hr_lsb, set_min_msb, set_min_lsb,
           set_sec_msb, set_sec_lsb, set_en, field_sel
  );

  modport slave (
    input  mode_btn, inc_btn, cur,
    output set_hr_msb, set_hr_lsb, set_min_msb, set_min_lsb,
           set_sec_msb, set_sec_lsb, set_en, field_sel
  );

endinterface

// File: rtl/bcd2_inc.sv
// Two-digit BCD incrementer with wrap to 00 at the limit; malformed or
// out-of-range inputs also wrap to 00.
module bcd2_inc
  import watch_pkg::*;
#(
  parameter int unsigned MAX_W = LIMIT_W
) (
  input  bcd2_t            value,
  input  logic [MAX_W-1:0] limit,
  output bcd2_t            result_c
);

  logic [MAX_W-1:0] bin_c;
  logic             wrap_c;

  always_comb begin
    result_c = '0;
    bin_c    = MAX_W'(value.msb) * MAX_W'(10) + MAX_W'(value.lsb);
    wrap_c   = (value.msb > 4'd9) || (value.lsb > 4'd9) || (bin_c >= limit);
    if (!wrap_c) begin
      if (value.lsb == 4'd9) begin
        result_c.msb = 4'(value.msb + 4'd1);
        result_c.lsb = 4'd0;
      end else begin
        result_c.msb = value.msb;
        result_c.lsb = 4'(value.lsb + 4'd1);
      end
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Mode/increment editor for the watch time: captures live time, edits one
// BCD field at a time, and commits on the last mode press or on idle timeout.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_sec_lsb,
  input  logic [3:0] cur_sec_msb,
  input  logic [3:0] cur_min_lsb,
  input  logic [3:0] cur_min_msb,
  input  logic [3:0] cur_hr_lsb,
  input  logic [3:0] cur_hr_msb,
  output logic [3:0] set_sec_lsb,
  output logic [3:0] set_sec_msb,
  output logic [3:0] set_min_lsb,
  output logic [3:0] set_min_msb,
  output logic [3:0] set_hr_lsb,
  output logic [3:0] set_hr_msb,
  output logic       set_en,
  output logic [1:0] field_sel
);

  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  hms_t               edit_q, edit_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               set_en_d;
  logic [1:0]         field_sel_d;
  hms_t               cur_c;
  bcd2_t              fld_c, fld_inc_c;
  logic [LIMIT_W-1:0] limit_c;

  assign cur_c = {cur_hr_msb, cur_hr_lsb, cur_min_msb, cur_min_lsb, cur_sec_msb, cur_sec_lsb};

  // Route the field being edited, and its limit, through the shared incrementer.
  always_comb begin
    fld_c   = edit_q.hr;
    limit_c = HR_MAX;
    unique case (state_q)
      ST_SET_MIN: begin fld_c = edit_q.min; limit_c = MS_MAX; end
      ST_SET_SEC: begin fld_c = edit_q.sec; limit_c = MS_MAX; end
      default:    begin fld_c = edit_q.hr;  limit_c = HR_MAX; end
    endcase
  end

  bcd2_inc #(.MAX_W(LIMIT_W)) u_inc (
    .value    (fld_c),
    .limit    (limit_c),
    .result_c (fld_inc_c)
  );

  // Next state; mode beats inc, and any button press beats the timeout.
  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    idle_d  = '0;
    unique case (state_q)
      ST_RUN: begin
        if (mode_btn) begin
          state_d = ST_SET_HR;
          edit_d  = cur_c;
        end
      end
      ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
        if (mode_btn) begin
          unique case (state_q)
            ST_SET_HR:  state_d = ST_SET_MIN;
            ST_SET_MIN: state_d = ST_SET_SEC;
            default:    state_d = ST_COMMIT;
          endcase
        end else if (inc_btn) begin
          unique case (state_q)
            ST_SET_HR:  edit_d.hr  = fld_inc_c;
            ST_SET_MIN: edit_d.min = fld_inc_c;
            default:    edit_d.sec = fld_inc_c;
          endcase
        end else if (idle_q == IDLE_LAST) begin
          state_d = ST_COMMIT;
        end else begin
          idle_d = IDLE_W'(idle_q + 1'b1);
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    set_en_d    = (state_d != ST_RUN);
    field_sel_d = field_of(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      edit_q    <= '0;
      idle_q    <= '0;
      set_en    <= 1'b0;
      field_sel <= FS_NONE;
    end else begin
      state_q   <= state_d;
      edit_q    <= edit_d;
      idle_q    <= idle_d;
      set_en    <= set_en_d;
      field_sel <= field_sel_d;
    end
  end

  assign set_hr_msb  = edit_q.hr.msb;
  assign set_hr_lsb  = edit_q.hr.lsb;
  assign set_min_msb = edit_q.min.msb;
  assign set_min_lsb = edit_q.min.lsb;
  assign set_sec_msb = edit_q.sec.msb;
  assign set_sec_lsb = edit_q.sec.lsb;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl: directed scenarios plus random button
// traffic, checked against an arithmetic model of the editor.
`timescale 1ns/1ps
module tb_watch_set_ctrl;
  import watch_pkg::*;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  watch_set_ctrl_if bus();

  watch_set_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_btn    (bus.mode_btn),
    .inc_btn     (bus.inc_btn),
    .cur_sec_lsb (bus.cur.sec.lsb),
    .cur_sec_msb (bus.cur.sec.msb),
    .cur_min_lsb (bus.cur.min.lsb),
    .cur_min_msb (bus.cur.min.msb),
    .cur_hr_lsb  (bus.cur.hr.lsb),
    .cur_hr_msb  (bus.cur.hr.msb),
    .set_sec_lsb (bus.set_sec_lsb),
    .set_sec_msb (bus.set_sec_msb),
    .set_min_lsb (bus.set_min_lsb),
    .set_min_msb (bus.set_min_msb),
    .set_hr_lsb  (bus.set_hr_lsb),
    .set_hr_msb  (bus.set_hr_msb),
    .set_en      (bus.set_en),
    .field_sel   (bus.field_sel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [26:0] exp_q[$];
  logic [23:0] cur_t = 24'h0;

  // Model: mode 0 = running, 1..3 = editing hr/min/sec, 4 = one-cycle commit.
  int m_mode = 0;
  int m_idle = 0;
  int m_d[6] = '{0, 0, 0, 0, 0, 0};

  function automatic logic [26:0] mk(input bit en, input logic [1:0] fs, input logic [23:0] t);
    return {en, fs, t};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {bus.set_en, bus.field_sel, bus.set_hr_msb, bus.set_hr_lsb,
            bus.set_min_msb, bus.set_min_lsb, bus.set_sec_msb, bus.set_sec_lsb};
  endfunction

  function automatic logic [26:0] model_vec();
    logic [26:0] v;
    v[26]    = (m_mode != 0);
    v[25:24] = (m_mode >= 1 && m_mode <= 3) ? 2'(m_mode) : 2'd0;
    for (int k = 0; k < 6; k++) v[23-4*k -: 4] = 4'(m_d[k]);
    return v;
  endfunction

  function automatic void model_inc(input int field);
    int b, lim, val;
    b   = (field - 1) * 2;
    lim = (field == 1) ? 23 : 59;
    val = m_d[b] * 10 + m_d[b+1];
    if (m_d[b] > 9 || m_d[b+1] > 9 || val >= lim) val = 0;
    else val = val + 1;
    m_d[b]   = val / 10;
    m_d[b+1] = val % 10;
  endfunction

  function automatic void model_step(input bit m, input bit i);
    if (m_mode == 0) begin
      if (m) begin
        for (int k = 0; k < 6; k++) m_d[k] = int'(cur_t[23-4*k -: 4]);
        m_mode = 1;
        m_idle = 0;
      end
    end else if (m_mode <= 3) begin
      if (m) begin
        m_mode = m_mode + 1;
        m_idle = 0;
      end else if (i) begin
        model_inc(m_mode);
        m_idle = 0;
      end else if (m_idle == TMO - 1) begin
        m_mode = 4;
        m_idle = 0;
      end else begin
        m_idle = m_idle + 1;
      end
    end else begin
      m_mode = 0;
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_idle = 0;
    for (int k = 0; k < 6; k++) m_d[k] = 0;
  endfunction

  // One clock of stimulus; returns shortly after the rising edge.
  task automatic cyc(input bit m, input bit i);
    @(negedge clk);
    bus.mode_btn = m;
    bus.inc_btn  = i;
    bus.cur      = cur_t;
    model_step(m, i);
    exp_q.push_back(model_vec());
    mon_en = 1'b1;
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string name, input logic [26:0] exp);
    logic [26:0] got;
    got = dut_vec();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic to_run();
    while (m_mode != 0) cyc(1'b1, 1'b0);
  endtask

  function automatic logic [23:0] rnd_time();
    logic [23:0] t;
    t = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    if ($urandom_range(0, 7) == 0) t[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(0, 15));
    return t;
  endfunction

  // Monitor: every rising edge while enabled, the DUT presents one output set.
  always begin
    logic [26:0] e;
    @(posedge clk);
    #2;
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow got=%h exp=<none>", dut_vec());
      end else begin
        e = exp_q.pop_front();
        if (dut_vec() !== e) begin
          errors++;
          $display("FAIL scoreboard got=%h exp=%h", dut_vec(), e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    bus.cur      = '0;
    #1 rst_n = 1'b0;
    #2 chk("reset_init", mk(1'b0, 2'd0, 24'h0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Capture and hour edit
    cur_t = 24'h034553;
    cyc(1, 0); chk("capture", mk(1, 2'd1, 24'h034553));
    cyc(0, 1); chk("hr_inc", mk(1, 2'd1, 24'h044553));
    to_run();  chk("back_to_run", mk(0, 2'd0, 24'h044553));
    cyc(0, 1); chk("inc_in_run", mk(0, 2'd0, 24'h044553));

    // Hour wrap and tens carry
    cur_t = 24'h221000;
    cyc(1, 0); cyc(0, 1); chk("hr_22_23", mk(1, 2'd1, 24'h231000));
    cyc(0, 1); chk("hr_wrap", mk(1, 2'd1, 24'h001000));
    to_run();
    cur_t = 24'h190000;
    cyc(1, 0); cyc(0, 1); chk("hr_19_20", mk(1, 2'd1, 24'h200000));
    to_run();

    // Full walk with commit
    cur_t = 24'h065955;
    cyc(1, 0);
    cyc(0, 1); chk("walk_hr", mk(1, 2'd1, 24'h075955));
    cyc(1, 0);
    cyc(0, 1); chk("walk_min_wrap", mk(1, 2'd2, 24'h070055));
    cyc(1, 0);
    cyc(0, 1); chk("walk_sec", mk(1, 2'd3, 24'h070056));
    cyc(1, 0); chk("commit", mk(1, 2'd0, 24'h070056));
    cyc(0, 0); chk("commit_run", mk(0, 2'd0, 24'h070056));

    // Simultaneous buttons
    cur_t = 24'h123456;
    cyc(1, 0); cyc(1, 0); chk("enter_min", mk(1, 2'd2, 24'h123456));
    cyc(1, 1); chk("mode_priority", mk(1, 2'd3, 24'h123456));
    to_run();

    // Out-of-range and malformed captured fields
    cur_t = 24'h256A00;
    cyc(1, 0); cyc(0, 1); chk("hr_invalid_wrap", mk(1, 2'd1, 24'h006A00));
    cyc(1, 0); cyc(0, 1); chk("min_invalid_wrap", mk(1, 2'd2, 24'h000000));
    to_run();

    // Idle timeout
    cur_t = 24'h102030;
    cyc(1, 0); cyc(0, 1); cyc(1, 0); chk("tmo_enter", mk(1, 2'd2, 24'h112030));
    repeat (TMO - 1) cyc(0, 0);
    chk("tmo_not_yet", mk(1, 2'd2, 24'h112030));
    cyc(0, 0); chk("tmo_commit", mk(1, 2'd0, 24'h112030));
    cyc(0, 0); chk("tmo_run", mk(0, 2'd0, 24'h112030));

    // Reset mid-edit
    cur_t = 24'h081542;
    cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(0, 1);
    chk("pre_reset", mk(1, 2'd3, 24'h081543));
    mon_en = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset_async", mk(0, 2'd0, 24'h0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0); chk("after_reset", mk(0, 2'd0, 24'h0));

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit m, i;
      if ($urandom_range(0, 3) == 0) cur_t = rnd_time();
      if ((n % 60) >= 48) begin
        m = 1'b0;
        i = 1'b0;
      end else begin
        m = ($urandom_range(0, 5) == 0);
        i = ($urandom_range(0, 2) == 0);
      end
      cyc(m, i);
    end

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/watch_set_ctrl.md
WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles in any SET state before automatic commit.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port mode_btn  input  1  single-cycle pulse that advances the edit mode; debounced upstream.
REQ-005 SHALL have port inc_btn  input  1  single-cycle pulse that increments the selected field; debounced upstream.
REQ-006 SHALL have ports cur_sec_lsb, cur_sec_msb, cur_min_lsb, cur_min_msb, cur_hr_lsb, cur_hr_msb  input  4 each  live BCD time from the watch.
REQ-007 SHALL have ports set_sec_lsb, set_sec_msb, set_min_lsb, set_min_msb, set_hr_lsb, set_hr_msb  output  4 each  BCD time driven to the watch set inputs.
REQ-008 SHALL have port set_en  output  1  watch load/freeze strobe.
REQ-009 SHALL have port field_sel  output  2  selected field: 0 none, 1 hr, 2 min, 3 sec.

Function
REQ-010 SHALL implement FSM states RUN, SET_HR, SET_MIN, SET_SEC, COMMIT.
REQ-011 SHALL transition on mode_btn: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->SET_SEC, SET_SEC->COMMIT.
REQ-012 SHALL leave COMMIT for RUN unconditionally after exactly one cycle; buttons in COMMIT are ignored.
REQ-013 SHALL capture all six cur_* digits into the edit registers on the RUN->SET_HR edge.
REQ-014 SHALL drive set_* outputs directly from the edit registers at all times, with no combinational path from inputs.
REQ-015 SHALL drive set_en=1 in SET_HR, SET_MIN, SET_SEC and COMMIT, and set_en=0 in RUN.
REQ-016 SHALL assert set_en and present the captured digits in the same cycle: one cycle after the mode_btn sample.
REQ-017 SHALL, on inc_btn in a SET state, increment only the selected two-digit BCD field, with the result visible one cycle later.
REQ-018 SHALL wrap hours 23->00, with 09->10 and 19->20 carrying into the high digit.
REQ-019 SHALL wrap minutes and seconds 59->00, with x9->(x+1)0 carrying into the high digit.
REQ-020 SHALL treat a captured field that is at or above its maximum, or that contains a digit above 9, as wrapping to 00 on the next increment.
REQ-021 SHALL give mode_btn priority when mode_btn and inc_btn arrive in the same cycle: the state advances and inc is discarded.
REQ-022 SHALL ignore inc_btn in RUN and COMMIT.
REQ-023 SHALL keep an idle counter that clears on any button pulse and on entry to a SET state, and counts in SET states.
REQ-024 SHALL go to COMMIT when the idle counter reaches TIMEOUT_CYCLES-1 in a SET state, keeping the edited values.
REQ-025 SHALL size the idle counter as $clog2(TIMEOUT_CYCLES) bits, with no overflow possible.
REQ-026 SHALL set field_sel to 1, 2 or 3 in SET_HR, SET_MIN or SET_SEC respectively, and to 0 otherwise.

Reset
REQ-027 SHALL, on rst_n low, immediately force state RUN, set_en 0, field_sel 0, all set_* digits 0 and the idle counter 0, independent of clk.
REQ-028 SHALL abandon any edit in progress when reset asserts mid-edit, with no commit pulse produced.
REQ-029 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-030 SHALL place the state enum, field_sel encodings and the BCD limit constants (HR_MAX 23, MS_MAX 59) in shared package watch_pkg.
REQ-031 SHALL instantiate one sub-module, bcd2_inc: a two-digit BCD incrementer, parameterised by maximum value, with wrap-to-00.
REQ-032 SHALL use bcd2_inc for every field, selected through a mux by state.

Verification
REQ-033 SHALL verify capture and hour edit: cur=03:45:53, then mode, then inc x1 -> set_en=1, set_*=04:45:53, field_sel=1.
REQ-034 SHALL verify hour wrap: capture 22:10:00, then inc x2 in SET_HR -> 00:10:00, with 19->20 carry checked from 19:00:00.
REQ-035 SHALL verify full walk and commit: mode x4 with inc in each field on 06:59:55 -> 07:00:56, one COMMIT cycle with set_en=1, then RUN with set_en=0.
REQ-036 SHALL verify simultaneous buttons: mode_btn and inc_btn together in SET_MIN -> state SET_SEC, minutes unchanged.
REQ-037 SHALL verify timeout with TIMEOUT_CYCLES=8: enter SET_MIN, then idle 8 cycles -> COMMIT, then RUN, with edits retained on set_*.
REQ-038 SHALL verify reset mid-edit: rst_n low in SET_SEC between clk edges -> immediately RUN, set_en=0, all digits 0.
